// File: rtl/psg_channel_mixer.sv
// psg_channel_mixer
//   Mixes the attenuated samples of all PSG channels into one signed 16-bit
//   sample per output period. A free-running divider marks each period. On
//   every period the mixer raises `step` so the attenuators publish fresh
//   samples, then takes a snapshot of them. It sums the snapshot one channel
//   per cycle into a wide accumulator and presents the saturated result on a
//   valid/ready handshake. Periods that arrive while the previous sample is
//   still being produced or held are dropped and counted; they are not queued.
module psg_channel_mixer #(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_DIV  = 2268,
  parameter int STEP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [16*NUM_CH-1:0]  ch_sample,
  input  logic [NUM_CH-1:0]     ch_valid,
  output logic                  step,
  output logic [15:0]           mix_out,
  output logic                  mix_valid,
  input  logic                  mix_ready,
  output logic [7:0]            drop_cnt
);

  // Accumulator is wide enough that NUM_CH full-scale samples never wrap.
  localparam int ACC_W  = 16 + $clog2(NUM_CH) + 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [DIV_W-1:0]         DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [STEP_W-1:0]        STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX   = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0]  SAT_MIN   = ACC_W'(-32768);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_SETTLE,
    S_SUM,
    S_OUT
  } state_t;

  // Clamp the wide accumulator into the signed 16-bit output range.
  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return 16'h7FFF;
    end else if (v < SAT_MIN) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [STEP_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      step_q, step_d;
  logic [15:0]               mix_out_q, mix_out_d;
  logic                      mix_valid_q, mix_valid_d;
  logic [7:0]                drop_q, drop_d;
  logic signed [15:0]        snap_q [NUM_CH];
  logic signed [15:0]        snap_d [NUM_CH];
  logic [NUM_CH-1:0]         snap_valid_q, snap_valid_d;

  logic                      tick;
  logic signed [15:0]        ch_word [NUM_CH];
  logic signed [15:0]        sel_sample;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_sum;

  // Split the flat channel bus into one signed word per channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_word[gi] = ch_sample[16*gi +: 16];
  end

  // Divider: free-running sample grid, never stalled by the FSM.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Drop counter: a period that finds the mixer busy is lost and counted.
  always_comb begin
    drop_d = drop_q;
    if (tick && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Current accumulator term: the snapshot of channel idx, or 0 if invalid.
  always_comb begin
    sel_sample = snap_q[idx_q];
    term       = '0;
    if (snap_valid_q[idx_q]) begin
      term = {{(ACC_W-16){sel_sample[15]}}, sel_sample};
    end
    acc_sum = acc_q + term;
  end

  // Sequencer next-state: step request, snapshot, serial sum, handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    step_d       = step_q;
    mix_out_d    = mix_out_q;
    mix_valid_d  = mix_valid_q;
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_STEP;
          cnt_d   = '0;
          step_d  = 1'b1;
        end
      end

      S_STEP: begin
        if (cnt_q == STEP_LAST) begin
          state_d = S_SETTLE;
          step_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SETTLE: begin
        // Freeze the inputs so later changes cannot disturb this sum.
        snap_d       = ch_word;
        snap_valid_d = ch_valid;
        acc_d        = '0;
        idx_d        = '0;
        state_d      = S_SUM;
      end

      S_SUM: begin
        acc_d = acc_sum;
        if (idx_q == IDX_LAST) begin
          state_d     = S_OUT;
          mix_out_d   = sat16(acc_sum);
          mix_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_OUT: begin
        if (mix_ready) begin
          state_d     = S_IDLE;
          mix_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        step_d      = 1'b0;
        mix_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset clears step at once and discards any partial sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      step_q       <= 1'b0;
      mix_out_q    <= '0;
      mix_valid_q  <= 1'b0;
      drop_q       <= '0;
      snap_valid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      step_q       <= step_d;
      mix_out_q    <= mix_out_d;
      mix_valid_q  <= mix_valid_d;
      drop_q       <= drop_d;
      snap_valid_q <= snap_valid_d;
      snap_q       <= snap_d;
    end
  end

  assign step      = step_q;
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_psg_channel_mixer.sv
// tb_psg_channel_mixer
//   Scenario tasks drive the mixer with fixed and random sample periods and
//   compare the recorded behaviour with a reference model. That model works
//   from whole-period arithmetic: the sum of the valid channels clipped to
//   16 bits, and the count of periods that fall inside a busy window.
module tb_psg_channel_mixer;

  localparam int NUM_CH      = 4;
  localparam int SAMPLE_DIV  = 16;
  localparam int STEP_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] ch_sample;
  logic [3:0]  ch_valid;
  logic        step;
  logic [15:0] mix_out;
  logic        mix_valid;
  logic        mix_ready;
  logic [7:0]  drop_cnt;

  psg_channel_mixer #(
    .NUM_CH      (NUM_CH),
    .SAMPLE_DIV  (SAMPLE_DIV),
    .STEP_CYCLES (STEP_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_sample (ch_sample),
    .ch_valid  (ch_valid),
    .step      (step),
    .mix_out   (mix_out),
    .mix_valid (mix_valid),
    .mix_ready (mix_ready),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; a period boundary is cyc % 16 == 15.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_pass  = 0;
  int n_total = 0;

  // Scheduling and model state.
  int t_next;       // next period the mixer will accept
  int drop_total;   // model count of dropped periods (unsaturated)

  // Observations of the most recent period, relative to its tick cycle.
  int          step_first, step_last, step_count;
  int          valid_first, valid_last, valid_count;
  int          drop_at_accept;
  bit          idle_glitch, out_changed;
  logic [15:0] out_first;

  // Reference mix: plain integer sum of the valid channels, clipped.
  function automatic logic [15:0] ref_mix(input logic [63:0] v, input logic [3:0] m);
    int sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) sum += int'($signed(v[16*i +: 16]));
    end
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    return 16'(sum);
  endfunction

  // Periods dropped before the handshake cycle, and in total, for a
  // consumer that accepts d cycles after the sample appears 8 cycles in.
  function automatic int ref_drop_before(input int d);
    int v = drop_total + (7 + d) / SAMPLE_DIV;
    return (v > 255) ? 255 : v;
  endfunction

  // Advance to a target cycle, noting any activity while the mixer is idle.
  task automatic goto_cycle(input int target);
    int guard = 0;
    idle_glitch = 0;
    while (cyc != target && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (step || mix_valid) idle_glitch = 1;
    end
    if (cyc != target) begin
      n_total++;
      $display("FAIL goto_cycle: at cycle %0d, required cycle %0d", cyc, target);
    end
  endtask

  // Run one period: present inputs at the tick, optionally scramble them
  // during the sum, and accept the result d cycles after it appears.
  task automatic drive_sample(input logic [63:0] smp, input logic [3:0] vm,
                              input int d, input bit mid_change);
    int t0;
    goto_cycle(t_next);
    t0 = cyc;
    ch_sample = smp;
    ch_valid  = vm;
    step_first = -1; step_last = -1; step_count = 0;
    valid_first = -1; valid_last = -1; valid_count = 0;
    drop_at_accept = -1; out_changed = 0; out_first = '0;
    for (int k = 0; k <= 9 + d; k++) begin
      if (k > 0) @(negedge clk);
      if (mid_change && k >= 4 && k <= 7) ch_sample = {$urandom, $urandom};
      if (k == 8 + d) begin
        mix_ready = 1'b1;
        drop_at_accept = int'(drop_cnt);
      end else if (k < 8) begin
        mix_ready = 1'($urandom);
      end else begin
        mix_ready = 1'b0;
      end
      if (step) begin
        if (step_first < 0) step_first = k;
        step_last = k;
        step_count++;
      end
      if (mix_valid) begin
        if (valid_first < 0) begin
          valid_first = k;
          out_first = mix_out;
        end else if (mix_out !== out_first) begin
          out_changed = 1;
        end
        valid_last = k;
        valid_count++;
      end
    end
    mix_ready = 1'b0;
    t_next = t0 + SAMPLE_DIV * ((8 + d) / SAMPLE_DIV + 1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({step, mix_valid} !== 2'b00)
      $display("FAIL reset_ctrl: step/mix_valid=%b%b required 00", step, mix_valid);
    else n_pass++;
    n_total++;
    if (mix_out !== 16'd0) $display("FAIL reset_mix_out: got %0d required 0", mix_out);
    else n_pass++;
    n_total++;
    if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt);
    else n_pass++;
    reset = 1'b0;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_basic();
    logic [63:0] smp = {16'd0, 16'hFFCE, 16'd200, 16'd100};
    drive_sample(smp, 4'b1111, 0, 0);
    $display("basic: mix_out=%0d valid_first=%0d", $signed(out_first), valid_first);
    n_total++;
    if (idle_glitch) $display("FAIL basic_idle: activity before first tick, got 1 required 0");
    else n_pass++;
    n_total++;
    if (step_first !== 1 || step_last !== 2 || step_count !== 2)
      $display("FAIL basic_step: first=%0d last=%0d count=%0d required 1/2/2",
               step_first, step_last, step_count);
    else n_pass++;
    n_total++;
    if (valid_first !== 8 || valid_count !== 1)
      $display("FAIL basic_valid: first=%0d count=%0d required 8/1", valid_first, valid_count);
    else n_pass++;
    n_total++;
    if (out_first !== 16'd250) $display("FAIL basic_sum: got %0d required 250", $signed(out_first));
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [63:0] pos = {4{16'd16000}};
    logic [63:0] neg = {4{16'hC180}};
    drive_sample(pos, 4'b1111, 0, 0);
    $display("sat_pos: mix_out=%0d", $signed(out_first));
    n_total++;
    if (out_first !== 16'h7FFF) $display("FAIL sat_pos: got %0d required 32767", $signed(out_first));
    else n_pass++;
    drive_sample(neg, 4'b1111, 0, 0);
    $display("sat_neg: mix_out=%0d", $signed(out_first));
    n_total++;
    if (out_first !== 16'h8000) $display("FAIL sat_neg: got %0d required -32768", $signed(out_first));
    else n_pass++;
  endtask

  task automatic test_snapshot();
    logic [63:0] smp = {4{16'd1000}};
    drive_sample(smp, 4'b0101, 0, 1);
    $display("snapshot: mix_out=%0d", $signed(out_first));
    n_total++;
    if (out_first !== 16'd2000) $display("FAIL snapshot_sum: got %0d required 2000", $signed(out_first));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] smp = {16'd7, 16'hFFF0, 16'd300, 16'd4};
    int exp_drop = ref_drop_before(40);
    drive_sample(smp, 4'b1111, 40, 0);
    $display("backpressure: held=%0d drop_cnt=%0d", valid_count, drop_at_accept);
    n_total++;
    if (valid_first !== 8 || valid_count !== 41)
      $display("FAIL bp_valid_held: first=%0d count=%0d required 8/41", valid_first, valid_count);
    else n_pass++;
    n_total++;
    if (out_changed || out_first !== ref_mix(smp, 4'b1111))
      $display("FAIL bp_mix_out: got %0d changed=%0d required %0d stable",
               $signed(out_first), out_changed, $signed(ref_mix(smp, 4'b1111)));
    else n_pass++;
    n_total++;
    if (step_count !== 2 || step_last !== 2)
      $display("FAIL bp_step_low: count=%0d last=%0d required 2/2", step_count, step_last);
    else n_pass++;
    n_total++;
    if (drop_at_accept !== exp_drop)
      $display("FAIL bp_drop_cnt: got %0d required %0d", drop_at_accept, exp_drop);
    else n_pass++;
    drop_total += (8 + 40) / SAMPLE_DIV;
    smp = {16'd1, 16'd2, 16'd3, 16'd4};
    drive_sample(smp, 4'b1111, 0, 0);
    $display("after_bp: mix_out=%0d valid_first=%0d", $signed(out_first), valid_first);
    n_total++;
    if (valid_first !== 8 || out_first !== 16'd10)
      $display("FAIL bp_next: first=%0d sum=%0d required 8/10", valid_first, $signed(out_first));
    else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [63:0] smp = {$urandom, $urandom};
      logic [3:0]  vm  = 4'($urandom);
      int          d   = int'($urandom_range(0, 40));
      bit          mid = 1'($urandom);
      logic [15:0] exp_out = ref_mix(smp, vm);
      int          exp_drop = ref_drop_before(d);
      drive_sample(smp, vm, d, mid);
      $display("random %0d: valid=%b d=%0d mix_out=%0d drop_cnt=%0d",
               n, vm, d, $signed(out_first), drop_at_accept);
      n_total++;
      if (out_first !== exp_out || out_changed)
        $display("FAIL rand_sum[%0d]: got %0d changed=%0d required %0d",
                 n, $signed(out_first), out_changed, $signed(exp_out));
      else n_pass++;
      n_total++;
      if (step_first !== 1 || step_count !== 2 || valid_first !== 8 || valid_count !== d + 1)
        $display("FAIL rand_timing[%0d]: step %0d/%0d valid %0d/%0d required 1/2 8/%0d",
                 n, step_first, step_count, valid_first, valid_count, d + 1);
      else n_pass++;
      n_total++;
      if (drop_at_accept !== exp_drop)
        $display("FAIL rand_drop[%0d]: got %0d required %0d", n, drop_at_accept, exp_drop);
      else n_pass++;
      drop_total += (8 + d) / SAMPLE_DIV;
    end
  endtask

  task automatic test_drop_saturate();
    logic [63:0] smp = {$urandom, $urandom};
    int exp_drop = ref_drop_before(4200);
    drive_sample(smp, 4'b1111, 4200, 0);
    $display("drop_saturate: drop_cnt=%0d", drop_at_accept);
    n_total++;
    if (drop_at_accept !== exp_drop)
      $display("FAIL drop_saturate: got %0d required %0d", drop_at_accept, exp_drop);
    else n_pass++;
    drop_total += (8 + 4200) / SAMPLE_DIV;
  endtask

  task automatic test_reset_mid();
    logic [63:0] smp;
    bit seen = 0;
    goto_cycle(t_next);
    ch_sample = {$urandom, $urandom};
    ch_valid  = 4'hF;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    $display("reset_mid: step=%b valid=%b mix_out=%0d drop_cnt=%0d",
             step, mix_valid, mix_out, drop_cnt);
    n_total++;
    if ({step, mix_valid} !== 2'b00 || mix_out !== 16'd0)
      $display("FAIL reset_mid_outputs: step/valid=%b%b mix_out=%0d required 00/0",
               step, mix_valid, mix_out);
    else n_pass++;
    n_total++;
    if (drop_cnt !== 8'd0) $display("FAIL reset_mid_drop: got %0d required 0", drop_cnt);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (step || mix_valid) seen = 1;
    end
    reset = 1'b0;
    t_next = SAMPLE_DIV - 1;
    drop_total = 0;
    n_total++;
    if (seen) $display("FAIL reset_mid_quiet: activity during reset, got 1 required 0");
    else n_pass++;
    smp = {16'd500, 16'hFE0C, 16'd123, 16'd77};
    drive_sample(smp, 4'b1011, 0, 0);
    $display("after_reset: mix_out=%0d valid_first=%0d", $signed(out_first), valid_first);
    n_total++;
    if (valid_first !== 8 || out_first !== ref_mix(smp, 4'b1011))
      $display("FAIL reset_mid_next: first=%0d sum=%0d required 8/%0d",
               valid_first, $signed(out_first), $signed(ref_mix(smp, 4'b1011)));
    else n_pass++;
  endtask

  initial begin
    ch_sample  = '0;
    ch_valid   = '0;
    mix_ready  = 1'b0;
    t_next     = SAMPLE_DIV - 1;
    drop_total = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_snapshot();
    test_backpressure();
    test_random();
    test_drop_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
